// File: rtl/uart_rx_fifo_if.sv
// Receive-FIFO bus: serial line in; show-ahead byte queue, pop strobe and sticky error flags.
interface uart_rx_fifo_if #(
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          rx;
  logic [7:0]    data;
  logic          valid;
  logic          read;
  logic [CW-1:0] count;
  logic          overrun;
  logic          frame_error;
  logic          clear_errors;

  modport master (
    output rx, read, clear_errors,
    input  data, valid, count, overrun, frame_error
  );

  modport slave (
    input  rx, read, clear_errors,
    output data, valid, count, overrun, frame_error
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with oversampling FSM feeding a show-ahead FIFO;
// sticky overrun / framing-error flags report lost or malformed bytes.
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ   = 27000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input logic           clk,
  input logic           reset,
  uart_rx_fifo_if.slave bus
);
  localparam int unsigned BIT_TICKS = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF      = BIT_TICKS / 2;
  localparam int unsigned PW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = PW + 1;
  localparam int unsigned TW        = $clog2(BIT_TICKS + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  // Synchroniser
  logic [1:0] sync_q;
  logic       rx_s;

  // Receiver
  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          at_half, at_bit, settled, sample;
  logic          push_req, ferr_set;

  // FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] rd_inc;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    data_q, data_d;
  logic          full, empty, pop, push_ok;

  // Flags
  logic overrun_q, overrun_d;
  logic ferr_q, ferr_d;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= {sync_q[0], bus.rx};
  end

  assign at_half = (tick_q == TW'(HALF - 1));
  assign at_bit  = (tick_q == TW'(BIT_TICKS - 1));
  // After reset the synchroniser still holds its reset value for two cycles;
  // waiting for it to flush keeps a low line from being mistaken for idle.
  assign settled = (tick_q >= TW'(2));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= WAIT_IDLE;
      tick_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_IDLE: if (rx_s && settled) state_d = IDLE;
      IDLE:      if (!rx_s) state_d = START;
      START:     if (at_half) state_d = rx_s ? IDLE : DATA;
      DATA:      if (at_bit && (bit_idx_q == 3'd7)) state_d = STOP;
      STOP:      if (at_bit) state_d = rx_s ? IDLE : WAIT_IDLE;
      default:   state_d = WAIT_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
    sample    = ((state_q == START) && at_half) ||
                (((state_q == DATA) || (state_q == STOP)) && at_bit);

    if ((state_d != state_q) || sample)          tick_d = '0;
    else if ((state_q == WAIT_IDLE) && settled)  tick_d = tick_q;
    else                                         tick_d = tick_q + TW'(1);

    case (state_q)
      START: if (at_half) bit_idx_d = '0;
      DATA: begin
        if (at_bit) begin
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (at_bit) begin
          push_req = rx_s;
          ferr_set = !rx_s;
        end
      end
      default: ;
    endcase
  end

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = bus.read && !empty;
  assign push_ok = push_req && (!full || pop);
  assign rd_inc  = rd_q + PW'(1);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    data_d  = data_q;
    if (push_ok) wr_d = wr_q + PW'(1);
    if (pop)     rd_d = rd_inc;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
    // The head register follows the entry that becomes head after this edge;
    // when the FIFO drains to one entry in the same cycle as a push, that is the new byte.
    if (pop) begin
      if (count_q != CW'(1)) data_d = mem_q[rd_inc];
      else if (push_ok)      data_d = shift_q;
      else                   data_d = '0;
    end else if (push_ok && empty) begin
      data_d = shift_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= shift_q;
  end

  always_comb begin
    overrun_d = (bus.clear_errors ? 1'b0 : overrun_q) | (push_req && full && !pop);
    ferr_d    = (bus.clear_errors ? 1'b0 : ferr_q) | ferr_set;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  assign bus.data        = data_q;
  assign bus.valid       = !empty;
  assign bus.count       = count_q;
  assign bus.overrun     = overrun_q;
  assign bus.frame_error = ferr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames in, scoreboard of expected bytes out.
module tb_uart_rx_fifo;
  localparam int unsigned CLK_FREQ  = 27000000;
  localparam int unsigned BAUD_RATE = 115200;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned BT        = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HF        = BT / 2;
  localparam int unsigned EXP_LAT   = 2 + HF + 9 * BT;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   lat;
  logic [7:0] sb[$];

  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.rx = fr[i];
      repeat (BT - 1) @(negedge clk);
    end
  endtask

  task automatic drain(input int unsigned n);
    logic [7:0] exp;
    for (int unsigned i = 0; i < n; i++) begin
      if (sb.size() == 0) begin
        check("scoreboard_underflow", 32'd0, 32'd1);
        exp = 8'h00;
      end else begin
        exp = sb.pop_front();
      end
      check("pop_valid", 32'(bus.valid), 32'd1);
      check("pop_data", 32'(bus.data), 32'(exp));
      bus.read = 1'b1;
      @(negedge clk);
    end
    bus.read = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, 32'(bus.valid), 32'd0);
    check({tag, "_data"}, 32'(bus.data), 32'd0);
    check({tag, "_count"}, 32'(bus.count), 32'd0);
  endtask

  task automatic check_flags(input string tag, input logic ovr, input logic fe);
    check({tag, "_overrun"}, 32'(bus.overrun), 32'(ovr));
    check({tag, "_frame_error"}, 32'(bus.frame_error), 32'(fe));
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.clear_errors = 1'b1;
    @(negedge clk);
    bus.clear_errors = 1'b0;
  endtask

  initial begin
    logic [7:0] tmp;
    checks           = 0;
    errors           = 0;
    reset            = 1'b0;
    bus.rx           = 1'b1;
    bus.read         = 1'b0;
    bus.clear_errors = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Reset state
    check_empty("reset");
    check_flags("reset", 1'b0, 1'b0);

    // Single byte with latency measurement
    sb.push_back(8'hA5);
    lat = -1;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        @(negedge clk);
        for (int k = 0; k < 4000; k++) begin
          @(negedge clk);
          if (bus.valid) begin
            lat = k;
            break;
          end
        end
      end
    join
    check("latency", 32'(lat), 32'(EXP_LAT));
    check("a5_count", 32'(bus.count), 32'd1);
    drain(1);
    check_empty("a5_popped");

    // Back-to-back frames, drained with read held high
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    sb.push_back(8'h5A);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    check("b2b_count", 32'(bus.count), 32'd3);
    check_flags("b2b", 1'b0, 1'b0);
    drain(3);
    check_empty("b2b_drained");

    // Framing error, then a good frame
    send_byte(8'h3C, 1'b0);
    bus.rx = 1'b1;
    repeat (BT) @(negedge clk);
    check("ferr_flag", 32'(bus.frame_error), 32'd1);
    check("ferr_count", 32'(bus.count), 32'd0);
    sb.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    check("ferr_next_count", 32'(bus.count), 32'd1);
    drain(1);
    pulse_clear();
    check_flags("ferr_cleared", 1'b0, 1'b0);

    // Short low glitch is rejected silently
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (40) @(negedge clk);
    bus.rx = 1'b1;
    repeat (BT) @(negedge clk);
    check_empty("glitch");
    check_flags("glitch", 1'b0, 1'b0);

    // Reset during bit 4 with the line held low afterwards
    tmp = 8'h77;
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (BT - 1) @(negedge clk);
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.rx = tmp[i];
      repeat (BT - 1) @(negedge clk);
    end
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (HF) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (11 * BT) @(negedge clk);
    check_empty("rst_low_line");
    check_flags("rst_low_line", 1'b0, 1'b0);
    bus.rx = 1'b1;
    repeat (BT) @(negedge clk);
    sb.push_back(8'hC3);
    send_byte(8'hC3, 1'b1);
    check("rst_next_count", 32'(bus.count), 32'd1);
    drain(1);

    // Overflow: 17 bytes into a 16-entry FIFO
    for (int unsigned i = 0; i < 17; i++) begin
      if (i < DEPTH) sb.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    check("ovf_count", 32'(bus.count), 32'(DEPTH));
    check("ovf_overrun", 32'(bus.overrun), 32'd1);
    pulse_clear();
    check("ovf_cleared", 32'(bus.overrun), 32'd0);

    // Push into a full FIFO coinciding with a pop
    sb.push_back(8'h11);
    fork
      send_byte(8'h11, 1'b1);
      begin
        @(negedge clk);
        repeat (EXP_LAT) @(negedge clk);
        tmp = sb.pop_front();
        check("coinc_head", 32'(bus.data), 32'(tmp));
        bus.read = 1'b1;
        @(negedge clk);
        bus.read = 1'b0;
      end
    join
    check("coinc_count", 32'(bus.count), 32'(DEPTH));
    check("coinc_overrun", 32'(bus.overrun), 32'd0);
    drain(DEPTH);
    check_empty("full_drained");
    check("sb_empty", 32'(sb.size()), 32'd0);

    // Read while empty is ignored
    bus.read = 1'b1;
    repeat (3) @(negedge clk);
    bus.read = 1'b0;
    check_empty("read_empty");
    check_flags("final", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
